data_cache: RTL

Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store unit and a multi-cycle backing memory. It replaces the fixed 16-bit-address RAM cache with a parametrised block:
- address width and set count are parameters;
- the backing memory sits behind a req/ack handshake;
- misses stall the CPU;
- loads return byte, halfword or word with sign or zero extension;
- stores merge byte lanes into a hit line.

---
 rtl/data_cache_pkg.sv | 70 +++++++
 rtl/data_cache_if.sv | 24 ++
 rtl/data_cache_line_array.sv | 49 ++++
 rtl/data_cache.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// rtl/data_cache_pkg.sv - shared types and byte-lane helpers for the data cache
// Holds the access-type and FSM state enums, the store lane bundle, and the
// pure functions that position store data and extract/extend load data.
package data_cache_pkg;

    typedef enum logic [1:0] {
        ACC_WORD = 2'b00,
        ACC_BYTE = 2'b01,
        ACC_HALF = 2'b10,
        ACC_RSVD = 2'b11
    } access_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WRITE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  be;
    } store_lanes_t;

    // Reserved type is always rejected; byte accesses are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] offset, input logic [1:0] acc);
        case (acc)
            ACC_WORD: return offset != 2'b00;
            ACC_HALF: return offset[0];
            ACC_BYTE: return 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] offset,
                                                 input logic [1:0] acc, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{offset, 3'b000} +: 8];
        h = offset[1] ? word[31:16] : word[15:0];
        case (acc)
            ACC_BYTE: return {{24{b[7] & ~is_unsigned}}, b};
            ACC_HALF: return {{16{h[15] & ~is_unsigned}}, h};
            ACC_WORD: return word;
            default:  return 32'd0;
        endcase
    endfunction

    // Data is replicated into every lane so the enables alone pick the target bytes.
    function automatic store_lanes_t store_lanes(input logic [31:0] wdata, input logic [1:0] offset,
                                                 input logic [1:0] acc);
        store_lanes_t r;
        case (acc)
            ACC_BYTE: begin
                r.data = {4{wdata[7:0]}};
                r.be   = 4'b0001 << offset;
            end
            ACC_HALF: begin
                r.data = {2{wdata[15:0]}};
                r.be   = offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                r.data = wdata;
                r.be   = 4'hF;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - backing memory req/ack bus between the cache and memory
// master: cache side (drives mem_req/we/addr/wdata/be, receives mem_ack/rdata)
// slave:  memory side (receives the request, returns one-cycle mem_ack with mem_rdata)
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_be;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_cache_line_array.sv
// rtl/data_cache_line_array.sv - tag/data storage and valid bits for the cache
// Ports: clk, rst (async clear of valid bits only), index (shared read/write set),
// rd_tag/rd_data/rd_valid (async read), wr_be/wr_data (byte-enabled data write),
// wr_fill/wr_tag (write tag and set valid on a line fill).
module data_cache_line_array #(
    parameter int SET_BITS = 6,
    parameter int TAG_W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SET_BITS-1:0] index,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [31:0]         rd_data,
    output logic                rd_valid,
    input  logic [3:0]          wr_be,
    input  logic [31:0]         wr_data,
    input  logic                wr_fill,
    input  logic [TAG_W-1:0]    wr_tag
);
    localparam int SETS = 1 << SET_BITS;

    logic [31:0]      data_mem [SETS];
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [SETS-1:0]  valid;

    assign rd_data  = data_mem[index];
    assign rd_tag   = tag_mem[index];
    assign rd_valid = valid[index];

    // Storage itself is never reset; only the valid vector is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                data_mem[index][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        if (wr_fill) begin
            tag_mem[index] <= wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_fill) begin
            valid[index] <= 1'b1;
        end
    end
endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through no-write-allocate data cache
// Ports: clk, rst (async active-high); cpu_* load/store request with cpu_rdata,
// cpu_stall and cpu_misaligned responses; mem (data_cache_if.master) to backing
// memory; hit_count/miss_count saturating load counters.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int SET_BITS   = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic [1:0]            cpu_type,
    input  logic                  cpu_unsigned,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  cpu_misaligned,
    data_cache_if.master          mem,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int TAG_W = ADDR_WIDTH - SET_BITS - 2;

    state_t state, state_next;

    logic [SET_BITS-1:0]   index;
    logic [TAG_W-1:0]      tag;
    logic [TAG_W-1:0]      line_tag;
    logic [31:0]           line_data;
    logic                  line_valid;
    logic                  hit;
    logic                  misaligned;
    logic                  access;
    store_lanes_t          lanes;

    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic                  wr_fill;
    logic                  hit_inc;
    logic                  miss_inc;
    logic                  issue;

    logic [31:0]           fill_word;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [3:0]            mem_be_q;

    assign index          = cpu_addr[SET_BITS+1:2];
    assign tag            = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
    assign misaligned     = is_misaligned(cpu_addr[1:0], cpu_type);
    assign access         = cpu_req && !misaligned;
    assign hit            = line_valid && (line_tag == tag);
    assign lanes          = store_lanes(cpu_wdata, cpu_addr[1:0], cpu_type);
    assign cpu_misaligned = cpu_req && misaligned;

    data_cache_line_array #(
        .SET_BITS (SET_BITS),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .index    (index),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .rd_valid (line_valid),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .wr_fill  (wr_fill),
        .wr_tag   (tag)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cpu_rdata  = 32'd0;
        cpu_stall  = 1'b0;
        wr_be      = 4'h0;
        wr_data    = lanes.data;
        wr_fill    = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    if (!cpu_we) begin
                        if (hit) begin
                            cpu_rdata = load_extract(line_data, cpu_addr[1:0], cpu_type, cpu_unsigned);
                            hit_inc   = 1'b1;
                        end else begin
                            cpu_stall  = 1'b1;
                            miss_inc   = 1'b1;
                            issue      = 1'b1;
                            state_next = S_FILL;
                        end
                    end else begin
                        // Write-through: a hit line is merged now, memory is written in WRITE.
                        cpu_stall  = 1'b1;
                        issue      = 1'b1;
                        state_next = S_WRITE;
                        if (hit) begin
                            wr_be = lanes.be;
                        end
                    end
                end
            end
            S_FILL: begin
                cpu_stall = 1'b1;
                if (mem.mem_ack) begin
                    wr_be      = 4'hF;
                    wr_data    = mem.mem_rdata;
                    wr_fill    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_WRITE: begin
                cpu_stall = !mem.mem_ack;
                if (mem.mem_ack) begin
                    state_next = S_IDLE;
                end
            end
            S_RESP: begin
                // The CPU still holds the request, so its address/type select the lane.
                cpu_rdata  = load_extract(fill_word, cpu_addr[1:0], cpu_type, cpu_unsigned);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            fill_word   <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            if (issue) begin
                mem_addr_q <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                if (cpu_we) begin
                    mem_wdata_q <= lanes.data;
                    mem_be_q    <= lanes.be;
                end else begin
                    mem_be_q    <= 4'hF;
                end
            end
            if (wr_fill) begin
                fill_word <= mem.mem_rdata;
            end
            if (hit_inc && hit_count != '1) begin
                hit_count <= hit_count + CNT_WIDTH'(1);
            end
            if (miss_inc && miss_count != '1) begin
                miss_count <= miss_count + CNT_WIDTH'(1);
            end
        end
    end

    // Request is decoded from the state register, so reset drops it immediately.
    assign mem.mem_req   = (state == S_FILL) || (state == S_WRITE);
    assign mem.mem_we    = (state == S_WRITE);
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;
endmodule
